// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer feeding a prefetch FIFO to decode over valid/ready.
// Optional FETCH_BOUNDS_CHECK_EN traps out-of-range fetches into a sticky FAULT state.
module fetch_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024,
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic [1:0]            state_o,
  output logic                  fault_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10, FAULT = 2'b11} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] pc, last_instr, last_pc;
  logic [DATA_WIDTH-1:0] buf_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, pop, redir, push_try, push, fault_hit;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign instr_valid_o = count != '0;
  assign pop = instr_valid_o && instr_ready_i;
  assign redir = redirect_i && state != FAULT;
  assign push_try = state == RUN && !redirect_i && (!full || pop);
`ifdef FETCH_BOUNDS_CHECK_EN
  assign fault_hit = push_try && ((pc >> 2) >= DATA_WIDTH'(MEM_SIZE));
  assign fault_o = state == FAULT;
`else
  assign fault_hit = 1'b0;
  assign fault_o = 1'b0;
`endif
  assign push = push_try && !fault_hit;
  assign imem_addr_o = pc;
  assign state_o = state;
  // An empty buffer keeps presenting the last head it showed.
  assign instr_o = instr_valid_o ? buf_instr[rd_ptr] : last_instr;
  assign instr_pc_o = instr_valid_o ? buf_pc[rd_ptr] : last_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= DATA_WIDTH'(RESET_PC);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      last_instr <= '0;
      last_pc <= '0;
    end else begin
      if (instr_valid_o) begin
        last_instr <= buf_instr[rd_ptr];
        last_pc <= buf_pc[rd_ptr];
      end
      if (push) begin
        buf_instr[wr_ptr] <= imem_instr_i;
        buf_pc[wr_ptr] <= pc;
      end
      if (redir) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          pc <= pc + DATA_WIDTH'(4);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (fault_hit) state <= FAULT;
      else if (halt_i && state == RUN) state <= HALTED;
      else if (start_i && !halt_i && (state == IDLE || state == HALTED)) state <= RUN;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl with a 16-word instruction memory model.
module tb_fetch_ctrl;
  logic clk = 0, rst = 1, start_i = 0, halt_i = 0, redirect_i = 0, instr_ready_i = 0;
  logic [31:0] redirect_pc_i = 0, imem_addr_o, imem_instr_i, instr_o, instr_pc_o;
  logic instr_valid_o, fault_o;
  logic [1:0] state_o;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] addr);
    logic [31:0] n;
    n = ((addr >> 2) % 16) + 1;
    return (n << 20) | (n << 7) | 32'h13;
  endfunction

  assign imem_instr_i = ins(imem_addr_o);

  fetch_ctrl #(.DATA_WIDTH(32), .MEM_SIZE(16), .FIFO_DEPTH(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .halt_i(halt_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .state_o(state_o), .fault_o(fault_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; start_i = 0; halt_i = 0; redirect_i = 0; instr_ready_i = 0;
    step();
    rst = 0;
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_valid", 32'(instr_valid_o), 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", instr_pc_o, 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_fault", 32'(fault_o), 0);
    chk("rst_addr", imem_addr_o, 0);
    // streaming with ready held high
    instr_ready_i = 1; start_i = 1;
    step();
    chk("t1_state", 32'(state_o), 1);
    chk("t1_valid0", 32'(instr_valid_o), 0);
    start_i = 0;
    step();
    chk("t1_valid1", 32'(instr_valid_o), 1);
    chk("t1_pc0", instr_pc_o, 32'h0);
    chk("t1_ins0", instr_o, 32'h00100093);
    step();
    chk("t1_pc4", instr_pc_o, 32'h4);
    chk("t1_ins4", instr_o, 32'h00200113);
    step();
    chk("t1_pc8", instr_pc_o, 32'h8);
    chk("t1_addr", imem_addr_o, 32'hC);
    // backpressure fills the buffer
    do_reset();
    start_i = 1;
    step();
    start_i = 0;
    step();
    chk("t2_addr4", imem_addr_o, 32'h4);
    step();
    chk("t2_addr8", imem_addr_o, 32'h8);
    step();
    chk("t2_hold", imem_addr_o, 32'h8);
    chk("t2_head0", instr_pc_o, 32'h0);
    instr_ready_i = 1;
    step();
    chk("t2_d4", instr_pc_o, 32'h4);
    chk("t2_addrC", imem_addr_o, 32'hC);
    step();
    chk("t2_d8", instr_pc_o, 32'h8);
    step();
    chk("t2_dC", instr_pc_o, 32'hC);
    chk("t2_vC", 32'(instr_valid_o), 1);
    // redirect flushes a full buffer with a pop in flight
    do_reset();
    start_i = 1;
    step();
    start_i = 0;
    step();
    step();
    redirect_i = 1; redirect_pc_i = 32'h23; instr_ready_i = 1;
    step();
    chk("t3_empty", 32'(instr_valid_o), 0);
    chk("t3_addr", imem_addr_o, 32'h20);
    chk("t3_hold", instr_pc_o, 32'h0);
    redirect_i = 0;
    step();
    chk("t3_v", 32'(instr_valid_o), 1);
    chk("t3_pc20", instr_pc_o, 32'h20);
    chk("t3_ins", instr_o, ins(32'h20));
    step();
    chk("t3_pc24", instr_pc_o, 32'h24);
    // halt wins over start, buffer drains while halted
    do_reset();
    start_i = 1;
    step();
    start_i = 0;
    step();
    halt_i = 1; start_i = 1;
    step();
    chk("t4_state", 32'(state_o), 2);
    chk("t4_addr", imem_addr_o, 32'h8);
    halt_i = 0; start_i = 0; instr_ready_i = 1;
    step();
    chk("t4_d4", instr_pc_o, 32'h4);
    chk("t4_frozen", imem_addr_o, 32'h8);
    step();
    chk("t4_drained", 32'(instr_valid_o), 0);
    chk("t4_last", instr_pc_o, 32'h4);
    start_i = 1;
    step();
    chk("t4_run", 32'(state_o), 1);
    start_i = 0;
    step();
    chk("t4_resume", instr_pc_o, 32'h8);
    chk("t4_addrC", imem_addr_o, 32'hC);
    // fetch past the end of a 16-word memory
    do_reset();
    redirect_i = 1; redirect_pc_i = 32'h3C;
    step();
    chk("t5_idle", 32'(state_o), 0);
    chk("t5_addr", imem_addr_o, 32'h3C);
    redirect_i = 0; start_i = 1; instr_ready_i = 1;
    step();
    start_i = 0;
    step();
    chk("t5_pc3C", instr_pc_o, 32'h3C);
    chk("t5_ins3C", instr_o, ins(32'h3C));
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("t5_state", 32'(state_o), 3);
    chk("t5_fault", 32'(fault_o), 1);
    chk("t5_novalid", 32'(instr_valid_o), 0);
    redirect_i = 1; redirect_pc_i = 32'h0; start_i = 1;
    step();
    chk("t5_ign_addr", imem_addr_o, 32'h40);
    chk("t5_ign_state", 32'(state_o), 3);
    redirect_i = 0; start_i = 0;
`else
    chk("t5_state", 32'(state_o), 1);
    chk("t5_fault", 32'(fault_o), 0);
    chk("t5_pc40", instr_pc_o, 32'h40);
    chk("t5_wrap", instr_o, 32'h00100093);
`endif
    do_reset();
    chk("t5_rst_state", 32'(state_o), 0);
    chk("t5_rst_fault", 32'(fault_o), 0);
    chk("t5_rst_addr", imem_addr_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
